// File: rtl/proximity_pkg.sv
// Shared types and constants for the ultrasonic distance filter slice.
package proximity_pkg;

  // Default sample width, in driver LSBs.
  localparam int unsigned DIST_W_DEF = 8;

  // A zero sample from the driver means no echo was received.
  localparam logic [DIST_W_DEF-1:0] NO_ECHO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FAR  = 2'd1,
    NEAR = 2'd2
  } prox_state_t;

endpackage

// File: rtl/window_buffer.sv
// Circular sample buffer with a running sum for a power-of-2 moving average.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears buffer and sum)
//   wr_en        write a new sample this cycle
//   prefill      with wr_en: fill every slot with din (restart the window)
//   din          sample to write
//   sum_next_c   combinational sum including din; valid when wr_en is high
module window_buffer #(
  parameter int unsigned DIST_W      = 8,
  parameter int unsigned LOG2_WINDOW = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic                          prefill,
  input  logic [DIST_W-1:0]             din,
  output logic [DIST_W+LOG2_WINDOW-1:0] sum_next_c
);

  localparam int unsigned SUM_W = DIST_W + LOG2_WINDOW;
  localparam int unsigned DEPTH = 1 << LOG2_WINDOW;

  logic [DIST_W-1:0]      mem_q [DEPTH];
  logic [DIST_W-1:0]      mem_d [DEPTH];
  logic [LOG2_WINDOW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]       sum_q, sum_d;

  // New sum: prefill seeds the whole window; otherwise add new, drop oldest.
  always_comb begin
    if (prefill) begin
      sum_next_c = SUM_W'(din) << LOG2_WINDOW;
    end else begin
      sum_next_c = sum_q + SUM_W'(din) - SUM_W'(mem_q[wr_ptr_q]);
    end
  end

  // Buffer, pointer and sum updates.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    if (wr_en) begin
      if (prefill) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem_d[i] = din;
        end
        wr_ptr_d = '0;
      end else begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + LOG2_WINDOW'(1);
      end
      sum_d = sum_next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      sum_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
    end
  end

endmodule

// File: rtl/distance_filter.sv
// Moving-average filter for ultrasonic distance samples with a hysteretic
// NEAR/FAR flag and a stale-sensor timeout.
// Ports:
//   CLOCK_50     system clock
//   reset        synchronous, active-high
//   dist_in      raw sample (0 = no echo, discarded)
//   dist_valid   1-cycle strobe qualifying dist_in
//   avg_out      filtered distance
//   avg_valid    1-cycle strobe, avg_out updated
//   near         proximity flag (level)
//   near_rise    1-cycle pulse on entry to NEAR
//   stale        no accepted sample for STALE_CYCLES clocks
module distance_filter
  import proximity_pkg::*;
#(
  parameter int unsigned       DIST_W       = DIST_W_DEF,
  parameter int unsigned       LOG2_WINDOW  = 2,
  parameter logic [DIST_W-1:0] NEAR_ON      = DIST_W'(20),
  parameter logic [DIST_W-1:0] NEAR_OFF     = DIST_W'(30),
  parameter int unsigned       STALE_CYCLES = 75_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  output logic [DIST_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              near,
  output logic              near_rise,
  output logic              stale
);

  localparam int unsigned SUM_W   = DIST_W + LOG2_WINDOW;
  localparam int unsigned TIMER_W = (STALE_CYCLES > 1) ? $clog2(STALE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_CNT = TIMER_W'(STALE_CYCLES - 1);

  prox_state_t         state_q, state_d;
  logic [DIST_W-1:0]   avg_out_q, avg_out_d;
  logic                avg_valid_q, avg_valid_d;
  logic                near_q, near_d;
  logic                near_rise_q, near_rise_d;
  logic                stale_q, stale_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;

  logic                accept_c;
  logic                timeout_c;
  logic [SUM_W-1:0]    sum_next_c;
  logic [DIST_W-1:0]   avg_new_c;

  assign accept_c  = dist_valid && (dist_in != DIST_W'(NO_ECHO));
  // An accepted sample in the timeout cycle wins over the timeout.
  assign timeout_c = (timer_q == TIMEOUT_CNT) && !accept_c;
  assign avg_new_c = DIST_W'(sum_next_c >> LOG2_WINDOW);

  // IDLE means the window must restart from the next sample.
  window_buffer #(
    .DIST_W      (DIST_W),
    .LOG2_WINDOW (LOG2_WINDOW)
  ) u_window_buffer (
    .clk        (CLOCK_50),
    .reset      (reset),
    .wr_en      (accept_c),
    .prefill    (state_q == IDLE),
    .din        (dist_in),
    .sum_next_c (sum_next_c)
  );

  // Next-state, timer and output logic.
  always_comb begin
    state_d     = state_q;
    avg_out_d   = avg_out_q;
    avg_valid_d = 1'b0;
    near_rise_d = 1'b0;
    stale_d     = stale_q;
    timer_d     = timer_q;

    if (accept_c) begin
      timer_d     = '0;
      stale_d     = 1'b0;
      avg_out_d   = avg_new_c;
      avg_valid_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (avg_new_c < NEAR_ON) begin
            state_d     = NEAR;
            near_rise_d = 1'b1;
          end else begin
            state_d = FAR;
          end
        end
        FAR: begin
          if (avg_new_c < NEAR_ON) begin
            state_d     = NEAR;
            near_rise_d = 1'b1;
          end
        end
        NEAR: begin
          if (avg_new_c >= NEAR_OFF) begin
            state_d = FAR;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_c) begin
      // Timer saturates here; the timeout simply re-asserts each cycle.
      stale_d = 1'b1;
      state_d = IDLE;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    near_d = (state_d == NEAR);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      avg_out_q   <= '0;
      avg_valid_q <= 1'b0;
      near_q      <= 1'b0;
      near_rise_q <= 1'b0;
      stale_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      avg_out_q   <= avg_out_d;
      avg_valid_q <= avg_valid_d;
      near_q      <= near_d;
      near_rise_q <= near_rise_d;
      stale_q     <= stale_d;
      timer_q     <= timer_d;
    end
  end

  assign avg_out   = avg_out_q;
  assign avg_valid = avg_valid_q;
  assign near      = near_q;
  assign near_rise = near_rise_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_distance_filter.sv
// Self-checking bench for distance_filter (window 4, stale after 100 cycles).
module tb_distance_filter;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] dist_in;
  logic       dist_valid;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       near;
  logic       near_rise;
  logic       stale;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0] avg;
    logic       near;
    logic       rise;
  } exp_t;

  exp_t exp_q[$];

  distance_filter #(
    .DIST_W       (8),
    .LOG2_WINDOW  (2),
    .NEAR_ON      (8'd20),
    .NEAR_OFF     (8'd30),
    .STALE_CYCLES (100)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .near       (near),
    .near_rise  (near_rise),
    .stale      (stale)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every avg_valid must match the oldest expected result.
  always @(negedge CLOCK_50) begin
    if (avg_valid) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_avg_valid: got avg_out=%0d, expected no strobe", avg_out);
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (avg_out !== e.avg) begin
          tests_failed++;
          $display("FAIL avg_out: got %0d, expected %0d", avg_out, e.avg);
        end
        tests_run++;
        if (near !== e.near) begin
          tests_failed++;
          $display("FAIL near_at_avg: got %0b, expected %0b (avg %0d)", near, e.near, e.avg);
        end
        tests_run++;
        if (near_rise !== e.rise) begin
          tests_failed++;
          $display("FAIL near_rise_at_avg: got %0b, expected %0b (avg %0d)", near_rise, e.rise, e.avg);
        end
      end
    end else if (near_rise) begin
      tests_run++;
      tests_failed++;
      $display("FAIL near_rise_alone: got 1 without avg_valid, expected 0");
    end
  end

  // Drive one sample (called at a negedge); push its expected result.
  task automatic send_sample(input logic [7:0] v, input logic [7:0] ea,
                             input logic en, input logic er);
    exp_q.push_back('{avg: ea, near: en, rise: er});
    dist_in    = v;
    dist_valid = 1'b1;
    @(negedge CLOCK_50);
    dist_valid = 1'b0;
  endtask

  // Wait until the scoreboard has consumed every expected result.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    dist_valid = 1'b0;
    dist_in    = '0;
    repeat (3) @(negedge CLOCK_50);
    tests_run++;
    if ({avg_out, avg_valid, near, near_rise, stale} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got avg=%0d v=%0b n=%0b r=%0b s=%0b, expected all 0",
               avg_out, avg_valid, near, near_rise, stale);
    end
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // 40 prefills the window, then averages fall into NEAR: IDLE->FAR->NEAR.
  task automatic test_filter();
    send_sample(8'd40, 8'd40, 1'b0, 1'b0);
    send_sample(8'd10, 8'd32, 1'b0, 1'b0);
    send_sample(8'd10, 8'd25, 1'b0, 1'b0);
    send_sample(8'd10, 8'd17, 1'b1, 1'b1);
    wait_drain("filter");
  endtask

  // Rising averages stay NEAR until reaching NEAR_OFF; no new rise pulse.
  task automatic test_hysteresis();
    send_sample(8'd30, 8'd15, 1'b1, 1'b0);
    send_sample(8'd30, 8'd20, 1'b1, 1'b0);
    send_sample(8'd30, 8'd25, 1'b1, 1'b0);
    send_sample(8'd30, 8'd30, 1'b0, 1'b0);
    wait_drain("hysteresis");
  endtask

  // Return to NEAR, then starve the filter; a zero sample must not reset the timer.
  task automatic test_stale();
    send_sample(8'd5, 8'd23, 1'b0, 1'b0);
    send_sample(8'd5, 8'd17, 1'b1, 1'b1);
    for (int k = 1; k <= 99; k++) begin
      dist_valid = (k == 50);
      dist_in    = '0;
      @(negedge CLOCK_50);
      if (k == 51) begin
        tests_run++;
        if (avg_out !== 8'd17) begin
          tests_failed++;
          $display("FAIL no_echo_avg_hold: got %0d, expected 17", avg_out);
        end
      end
    end
    dist_valid = 1'b0;
    tests_run++;
    if (stale !== 1'b0 || near !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_early: got stale=%0b near=%0b, expected stale=0 near=1", stale, near);
    end
    @(negedge CLOCK_50);
    tests_run++;
    if (stale !== 1'b1 || near !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_timeout: got stale=%0b near=%0b, expected stale=1 near=0", stale, near);
    end
    send_sample(8'd50, 8'd50, 1'b0, 1'b0);
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_clear: got %0b, expected 0", stale);
    end
  endtask

  // Accepted sample lands exactly in the timeout cycle.
  task automatic test_timeout_accept();
    for (int k = 1; k <= 99; k++) begin
      dist_valid = 1'b0;
      @(negedge CLOCK_50);
    end
    send_sample(8'd60, 8'd52, 1'b0, 1'b0);
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_in_timeout: got stale=%0b, expected 0", stale);
    end
  endtask

  // Discarded sample in the timeout cycle does not prevent the timeout.
  task automatic test_discard_timeout();
    for (int k = 1; k <= 100; k++) begin
      dist_valid = (k == 100);
      dist_in    = '0;
      @(negedge CLOCK_50);
      if (k == 99) begin
        tests_run++;
        if (stale !== 1'b0) begin
          tests_failed++;
          $display("FAIL discard_pre_timeout: got stale=%0b, expected 0", stale);
        end
      end
    end
    dist_valid = 1'b0;
    tests_run++;
    if (stale !== 1'b1) begin
      tests_failed++;
      $display("FAIL discard_in_timeout: got stale=%0b, expected 1", stale);
    end
    wait_drain("timeout");
  endtask

  // Reset has priority over a simultaneous valid sample.
  task automatic test_reset_with_valid();
    reset      = 1'b1;
    dist_in    = 8'd44;
    dist_valid = 1'b1;
    @(negedge CLOCK_50);
    tests_run++;
    if ({avg_out, avg_valid, near, near_rise, stale} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_with_valid: got avg=%0d v=%0b n=%0b r=%0b s=%0b, expected all 0",
               avg_out, avg_valid, near, near_rise, stale);
    end
    reset      = 1'b0;
    dist_valid = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // A close first sample goes straight from IDLE to NEAR with a single pulse.
  task automatic test_idle_near();
    send_sample(8'd5, 8'd5, 1'b1, 1'b1);
    @(negedge CLOCK_50);
    tests_run++;
    if (near_rise !== 1'b0 || near !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_near_pulse_width: got rise=%0b near=%0b, expected rise=0 near=1",
               near_rise, near);
    end
    wait_drain("idle_near");
  endtask

  initial begin
    test_reset();
    test_filter();
    test_hysteresis();
    test_stale();
    test_timeout_accept();
    test_discard_timeout();
    test_reset_with_valid();
    test_idle_near();
    repeat (3) @(negedge CLOCK_50);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
